// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: byte-command controller for regfile, ALU and TX FIFO.
// Ports: CLK/RST(async low), RX frame in, ALU ctrl/result, regfile port,
// TX FIFO push with FIFO_FULL backpressure, clk_div_en, CMD_ERR pulse.
// Optional burst commands 0xEE/0xFF enabled by macro SYS_CTRL_BURST_EN.
module sys_ctrl_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ALU_WIDTH  = 16,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  Rx_D_Vld,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_Valid,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  Gate_EN,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  RdEn,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL,
    output logic                  clk_div_en,
    output logic                  CMD_ERR
);

    localparam int NB = ALU_WIDTH / DATA_WIDTH;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_A,
        GET_B, GET_FUN, RD_WAIT, ALU_WAIT, PUSH
    } state_t;

    typedef enum logic [1:0] {C_WR, C_RD, C_BW, C_BR} cmd_t;

    state_t                state;
    cmd_t                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ALU_WIDTH-1:0]  result;
    logic [CW-1:0]         left;
`ifdef SYS_CTRL_BURST_EN
    logic [DATA_WIDTH-1:0] cnt;
`endif
    logic [7:0]            op;

    assign op = RX_P_DATA[7:0];

    // The push strobe must follow FIFO_FULL in the same cycle so that no
    // byte is written into a full FIFO; the byte itself is held in result.
    assign TX_D_VLD  = (state == PUSH) && !FIFO_FULL;
    assign TX_P_DATA = result[DATA_WIDTH-1:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cmd        <= C_WR;
            addr       <= '0;
            result     <= '0;
            left       <= '0;
`ifdef SYS_CTRL_BURST_EN
            cnt        <= '0;
`endif
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            Gate_EN    <= 1'b0;
            Address    <= '0;
            WrEn       <= 1'b0;
            WrData     <= '0;
            RdEn       <= 1'b0;
            clk_div_en <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            clk_div_en <= 1'b1;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            ALU_EN     <= 1'b0;
            CMD_ERR    <= 1'b0;
            case (state)
                IDLE: if (Rx_D_Vld) begin
                    case (op)
                        8'hAA: begin cmd <= C_WR; state <= GET_ADDR; end
                        8'hBB: begin cmd <= C_RD; state <= GET_ADDR; end
                        8'hCC: state <= GET_A;
                        8'hDD: state <= GET_FUN;
`ifdef SYS_CTRL_BURST_EN
                        8'hEE: begin cmd <= C_BW; state <= GET_ADDR; end
                        8'hFF: begin cmd <= C_BR; state <= GET_ADDR; end
`endif
                        default: CMD_ERR <= 1'b1;
                    endcase
                end
                GET_ADDR: if (Rx_D_Vld) begin
                    addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                    case (cmd)
                        C_WR: state <= GET_DATA;
                        C_RD: begin
                            RdEn    <= 1'b1;
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state   <= RD_WAIT;
                        end
                        default: state <= GET_CNT;
                    endcase
                end
`ifdef SYS_CTRL_BURST_EN
                GET_CNT: if (Rx_D_Vld) begin
                    if (RX_P_DATA == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= RX_P_DATA;
                        if (cmd == C_BW) begin
                            state <= GET_DATA;
                        end else begin
                            RdEn    <= 1'b1;
                            Address <= addr;
                            state   <= RD_WAIT;
                        end
                    end
                end
`endif
                GET_DATA: if (Rx_D_Vld) begin
                    WrEn    <= 1'b1;
                    Address <= addr;
                    WrData  <= RX_P_DATA;
`ifdef SYS_CTRL_BURST_EN
                    if (cmd == C_BW && cnt != DATA_WIDTH'(1)) begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                GET_A: if (Rx_D_Vld) begin
                    WrEn    <= 1'b1;
                    Address <= '0;
                    WrData  <= RX_P_DATA;
                    state   <= GET_B;
                end
                GET_B: if (Rx_D_Vld) begin
                    WrEn    <= 1'b1;
                    Address <= ADDR_WIDTH'(1);
                    WrData  <= RX_P_DATA;
                    state   <= GET_FUN;
                end
                GET_FUN: if (Rx_D_Vld) begin
                    ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                    ALU_EN  <= 1'b1;
                    Gate_EN <= 1'b1;
                    state   <= ALU_WAIT;
                end
                RD_WAIT: begin
                    if (Rx_D_Vld) CMD_ERR <= 1'b1;
                    if (RdData_Valid) begin
                        result <= ALU_WIDTH'(RdData);
                        left   <= CW'(1);
                        state  <= PUSH;
                    end
                end
                ALU_WAIT: begin
                    if (Rx_D_Vld) CMD_ERR <= 1'b1;
                    if (OUT_Valid) begin
                        result  <= ALU_OUT;
                        Gate_EN <= 1'b0;
                        left    <= CW'(NB);
                        state   <= PUSH;
                    end
                end
                PUSH: begin
                    if (Rx_D_Vld) CMD_ERR <= 1'b1;
                    if (!FIFO_FULL) begin
                        result <= result >> DATA_WIDTH;
                        left   <= left - 1'b1;
                        if (left == CW'(1)) begin
`ifdef SYS_CTRL_BURST_EN
                            // Burst read: next address only after this byte left.
                            if (cmd == C_BR && cnt != DATA_WIDTH'(1)) begin
                                cnt     <= cnt - 1'b1;
                                addr    <= addr + 1'b1;
                                Address <= addr + 1'b1;
                                RdEn    <= 1'b1;
                                state   <= RD_WAIT;
                            end else begin
                                state <= IDLE;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// tb_sys_ctrl_burst: scoreboard bench for sys_ctrl_burst.
// Directed byte commands; a negedge monitor pops expected strobes.
module tb_sys_ctrl_burst;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        Rx_D_Vld;
    logic [15:0] ALU_OUT;
    logic        OUT_Valid;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        Gate_EN;
    logic [3:0]  Address;
    logic        WrEn;
    logic [7:0]  WrData;
    logic        RdEn;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL;
    logic        clk_div_en;
    logic        CMD_ERR;

    sys_ctrl_burst dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .Rx_D_Vld(Rx_D_Vld),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .Gate_EN(Gate_EN),
        .Address(Address), .WrEn(WrEn), .WrData(WrData),
        .RdEn(RdEn), .RdData(RdData), .RdData_Valid(RdData_Valid),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .FIFO_FULL(FIFO_FULL), .clk_div_en(clk_div_en),
        .CMD_ERR(CMD_ERR)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [3:0] rq[$];
    logic [3:0] aq[$];
    logic [7:0] tq[$];
    int         eq_n;
    int         checks;
    int         errors;

    logic [7:0]  mem [16];
    logic [15:0] alu_val;
    int          alu_delay;
    logic        gate_exp;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected strobe value %h expected none", name, act);
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, ALU_EN, ALU_FUN, Gate_EN, Address, WrEn, WrData,
                RdEn, TX_P_DATA, TX_D_VLD, CMD_ERR, clk_div_en};
    endfunction

    // Monitor: every strobe cycle must match the next expected entry.
    always @(negedge CLK) begin
        if (RST) begin
            if (WrEn) begin
                if (wq.size() == 0) unexp("wr", {Address, WrData});
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr", {Address, WrData}, {w.a, w.d});
                end
            end
            if (RdEn) begin
                if (rq.size() == 0) unexp("rd", Address);
                else chk("rd", Address, rq.pop_front());
            end
            if (ALU_EN) begin
                if (aq.size() == 0) unexp("alu", ALU_FUN);
                else begin
                    chk("alu_fun", ALU_FUN, aq.pop_front());
                    chk("gate_at_en", Gate_EN, 1'b1);
                end
            end
            if (TX_D_VLD) begin
                if (tq.size() == 0) unexp("tx", TX_P_DATA);
                else chk("tx", TX_P_DATA, tq.pop_front());
            end
            if (CMD_ERR) begin
                if (eq_n == 0) unexp("cmd_err", 1);
                else eq_n--;
            end
        end
    end

    // Register-file model: data valid two cycles after RdEn.
    initial begin
        logic [3:0] a;
        RdData_Valid = 1'b0;
        RdData = '0;
        forever begin
            @(negedge CLK);
            if (RdEn) begin
                a = Address;
                @(posedge CLK);
                @(posedge CLK);
                #1 RdData = mem[a];
                RdData_Valid = 1'b1;
                @(posedge CLK);
                #1 RdData_Valid = 1'b0;
            end
        end
    end

    // ALU model: result after alu_delay cycles, Gate_EN checked then.
    initial begin
        OUT_Valid = 1'b0;
        ALU_OUT = '0;
        forever begin
            @(negedge CLK);
            if (ALU_EN) begin
                repeat (alu_delay) @(posedge CLK);
                #1 OUT_Valid = 1'b1;
                ALU_OUT = alu_val;
                @(negedge CLK);
                chk("gate_at_valid", Gate_EN, gate_exp);
                @(posedge CLK);
                #1 OUT_Valid = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        Rx_D_Vld = 1'b1;
        @(posedge CLK);
        #1 Rx_D_Vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 80; i++) begin
            if (wq.size() == 0 && rq.size() == 0 && aq.size() == 0 &&
                tq.size() == 0 && eq_n == 0) break;
            @(posedge CLK);
        end
        checks++;
        if (i == 80) begin
            errors++;
            $display("FAIL %s: pending wr=%0d rd=%0d alu=%0d tx=%0d err=%0d expected all 0",
                     name, wq.size(), rq.size(), aq.size(), tq.size(), eq_n);
            wq.delete(); rq.delete(); aq.delete(); tq.delete(); eq_n = 0;
        end
        idle(4);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; eq_n = 0;
        RST = 1'b0; RX_P_DATA = '0; Rx_D_Vld = 1'b0; FIFO_FULL = 1'b0;
        alu_val = '0; alu_delay = 3; gate_exp = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[2] = 8'h7E; mem[3] = 8'h5A; mem[15] = 8'h11; mem[0] = 8'h22;

        idle(2);
        chk("reset_outs", outs(), 32'h0);
        RST = 1'b1;
        idle(2);
        chk("clk_div_en", clk_div_en, 1'b1);
        chk("idle_outs", outs(), 32'h1);

        wq.push_back('{a: 4'h5, d: 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        wait_done("write");

        rq.push_back(4'h2); tq.push_back(8'h7E);
        send(8'hBB); send(8'h02);
        wait_done("read");

        wq.push_back('{a: 4'h0, d: 8'h10});
        wq.push_back('{a: 4'h1, d: 8'h03});
        aq.push_back(4'h0);
        tq.push_back(8'h13); tq.push_back(8'h00);
        alu_val = 16'h0013; alu_delay = 3; gate_exp = 1'b1;
        send(8'hCC); send(8'h10); send(8'h03); send(8'h00);
        begin
            int n;
            for (n = 0; n < 40; n++) begin
                @(negedge CLK);
                if (TX_D_VLD) break;
            end
            chk("first_tx_seen", (n < 40), 1'b1);
            @(posedge CLK);
            #1 FIFO_FULL = 1'b1;
            @(negedge CLK);
            chk("full_no_vld", TX_D_VLD, 1'b0);
            chk("full_hold", TX_P_DATA, 8'h00);
            repeat (5) @(posedge CLK);
            #1 FIFO_FULL = 1'b0;
        end
        wait_done("alu_cc");

        eq_n++;
        send(8'h12);
        wait_done("unknown_op");

        rq.push_back(4'h3); tq.push_back(8'h5A); eq_n++;
        send(8'hBB); send(8'h03); send(8'h77);
        wait_done("discard_rd_wait");

`ifdef SYS_CTRL_BURST_EN
        wq.push_back('{a: 4'hE, d: 8'hA1});
        wq.push_back('{a: 4'hF, d: 8'hA2});
        wq.push_back('{a: 4'h0, d: 8'hA3});
        send(8'hEE); send(8'h0E); send(8'h03);
        send(8'hA1); send(8'hA2); send(8'hA3);
        wait_done("burst_wr");

        send(8'hEE); send(8'h05); send(8'h00);
        wait_done("burst_wr_zero");

        rq.push_back(4'hF); tq.push_back(8'h11);
        rq.push_back(4'h0); tq.push_back(8'h22);
        send(8'hFF); send(8'h0F); send(8'h02);
        wait_done("burst_rd");
`else
        eq_n += 3;
        send(8'hFF); send(8'h01); send(8'h02);
        wait_done("ff_off");

        eq_n += 1;
        send(8'hEE);
        wait_done("ee_off");
`endif

        aq.push_back(4'h1);
        alu_val = 16'hBEEF; alu_delay = 6; gate_exp = 1'b0;
        send(8'hDD); send(8'h01);
        idle(2);
        chk("gate_in_wait", Gate_EN, 1'b1);
        RST = 1'b0;
        #1 chk("mid_reset_outs", outs(), 32'h0);
        idle(2);
        RST = 1'b1;
        idle(12);
        wait_done("reset_alu_wait");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_burst.md
SYS_CTRL_BURST -- requirements
Module: sys_ctrl_burst

Interface
REQ-001: The block SHALL have these parameters (name, default, meaning): DATA_WIDTH, 8, frame/register width; ADDR_WIDTH, 4, register address width; ALU_WIDTH, 16, ALU result width (integer multiple of DATA_WIDTH); FUN_WIDTH, 4, ALU function code width.
REQ-002: The block SHALL have these ports (name, direction, width, meaning): CLK, in, 1, single clock; all logic is on its rising edge.
REQ-003: RST, in, 1, reset; asynchronous assertion, active-low.
REQ-004: RX_P_DATA in DATA_WIDTH received frame; Rx_D_Vld in 1 one-cycle frame strobe.
REQ-005: ALU_OUT in ALU_WIDTH result; OUT_Valid in 1 result strobe; ALU_EN out 1 ALU start; ALU_FUN out FUN_WIDTH function; Gate_EN out 1 ALU clock-gate enable.
REQ-006: Address out ADDR_WIDTH; WrEn out 1; WrData out DATA_WIDTH; RdEn out 1; RdData in DATA_WIDTH; RdData_Valid in 1 (register-file port).
REQ-007: TX_P_DATA out DATA_WIDTH; TX_D_VLD out 1 FIFO write strobe; FIFO_FULL in 1 backpressure; clk_div_en out 1; CMD_ERR out 1 one-cycle error pulse.

Function
REQ-008: Opcodes: 0xAA write (addr, data); 0xBB read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU no operands (fun); 0xEE burst write (addr, N, N data); 0xFF burst read (addr, N); comparison on low 8 bits of RX_P_DATA.
REQ-009: States: IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN, RD_WAIT, ALU_WAIT, PUSH; each Rx_D_Vld-consumed byte advances one state.
REQ-010: Write byte SHALL produce WrEn=1 for exactly one cycle, the cycle after its Rx_D_Vld, with Address/WrData held that cycle.
REQ-011: Read SHALL pulse RdEn one cycle, wait in RD_WAIT for RdData_Valid, latch RdData, enter PUSH.
REQ-012: 0xCC SHALL write A to address 0 and B to address 1 (WrEn pulse each), then per fun byte drive ALU_FUN and ALU_EN=1 for one cycle; 0xDD skips the operand writes.
REQ-013: Gate_EN SHALL be 1 from the ALU_EN cycle until the cycle OUT_Valid is sampled, inclusive; ALU_OUT latched on OUT_Valid.
REQ-014: PUSH SHALL emit ALU_WIDTH/DATA_WIDTH bytes (ALU result, least-significant first) or one byte (read); TX_D_VLD=1 one cycle per byte only in cycles FIFO_FULL=0; under FIFO_FULL=1 TX_P_DATA holds and no byte is lost.
REQ-015: Burst: N=0 SHALL return to IDLE with no access; else N accesses to addr, addr+1, ... wrapping modulo 2^ADDR_WIDTH; burst read pushes each byte before issuing next RdEn.
REQ-016: Unknown opcode in IDLE SHALL pulse CMD_ERR and stay IDLE.
REQ-017: Rx_D_Vld in RD_WAIT, ALU_WAIT or PUSH SHALL discard the byte and pulse CMD_ERR; the command in progress continues.
REQ-018: clk_div_en SHALL be constant 1 out of reset.

Reset
REQ-019: On RST=0 state SHALL be IDLE, counters/latches cleared, all outputs 0 except clk_div_en=1 after release; reset mid-command abandons it with no further strobes.

Configuration
REQ-020: Macro SYS_CTRL_BURST_EN defined: 0xEE/0xFF supported per REQ-015; undefined: 0xEE/0xFF treated as unknown per REQ-016, burst counter logic absent.

Verification
REQ-021: AA,05,3C -> one WrEn cycle, Address=5, WrData=0x3C; no TX_D_VLD.
REQ-022: BB,02, RdData=0x7E valid 2 cycles later -> RdEn one pulse, TX_D_VLD once with 0x7E.
REQ-023: CC,10,03,00, ALU_OUT=0x0013 -> WrEn addr0=0x10, addr1=0x03, ALU_EN with fun 0, bytes 0x13 then 0x00; FIFO_FULL=1 for 5 cycles between bytes delays second byte, none lost.
REQ-024: EE,0E,03,A1,A2,A3 (macro on) -> writes at 0xE,0xF,0x0; EE,..,00 -> no WrEn.
REQ-025: FF,01,02 with macro off -> CMD_ERR at 0xFF; 0x01, 0x02 each give CMD_ERR, no strobes.
REQ-026: RST=0 during ALU_WAIT -> all outputs 0 immediately; later OUT_Valid produces no TX_D_VLD.
